// File: rtl/tlb_inv_ctrl.sv
// tlb_inv_ctrl: sequencer for the INVTLB instruction.
// It walks the TLB one entry per cycle. For each entry it evaluates the
// INVTLB op predicate and, on a hit, pulses the clear port for that entry.
// Optional feature macro: TLB_INV_FASTALL_EN. When defined, ops 0/1 skip the
// scan and clear every entry at once through clr_all in the DONE cycle.
module tlb_inv_ctrl #(
    parameter int TLBNUM = 16,
    parameter int IDX_W  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inv_req,
    input  logic [4:0]       inv_op,
    input  logic [9:0]       inv_asid,
    input  logic [18:0]      inv_vppn,
    output logic             inv_busy,
    output logic             inv_done,
    output logic             inv_ine,
    output logic [IDX_W-1:0] scan_idx,
    input  logic             scan_e,
    input  logic             scan_g,
    input  logic [9:0]       scan_asid,
    input  logic [18:0]      scan_vppn,
    input  logic [5:0]       scan_ps,
    output logic             clr_we,
    output logic [IDX_W-1:0] clr_idx,
    output logic             clr_all
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TLBNUM - 1);
    localparam logic [4:0]       OP_MAX   = 5'd6;

    logic [1:0]       state;
    logic [IDX_W-1:0] cnt;
    logic [4:0]       op_q;
    logic [9:0]       asid_q;
    logic [18:0]      vppn_q;
    logic             ine_q;
`ifdef TLB_INV_FASTALL_EN
    logic             fast_q;
`endif

    logic vmatch;
    logic amatch;
    logic pred;

    // Match predicate of the latched INVTLB op against the entry being scanned.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        pred   = 1'b0;
        vmatch = (scan_ps == 6'd21) ? (scan_vppn[18:9] == vppn_q[18:9])
                                    : (scan_vppn == vppn_q);
        amatch = (scan_asid == asid_q);
        case (op_q)
            5'd0, 5'd1: pred = 1'b1;
            5'd2:       pred = scan_g;
            5'd3:       pred = ~scan_g;
            5'd4:       pred = ~scan_g & amatch;
            5'd5:       pred = ~scan_g & amatch & vmatch;
            5'd6:       pred = (scan_g | amatch) & vmatch;
            default:    pred = 1'b0;
        endcase
    end

    // FSM, scan counter and operand latches.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            op_q   <= '0;
            asid_q <= '0;
            vppn_q <= '0;
            ine_q  <= 1'b0;
`ifdef TLB_INV_FASTALL_EN
            fast_q <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (inv_req) begin
                        op_q   <= inv_op;
                        asid_q <= inv_asid;
                        vppn_q <= inv_vppn;
                        cnt    <= '0;
                        ine_q  <= (inv_op > OP_MAX);
`ifdef TLB_INV_FASTALL_EN
                        fast_q <= (inv_op <= 5'd1);
                        if (inv_op > OP_MAX || inv_op <= 5'd1) begin
                            state <= S_DONE;
                        end else begin
                            state <= S_SCAN;
                        end
`else
                        if (inv_op > OP_MAX) begin
                            state <= S_DONE;
                        end else begin
                            state <= S_SCAN;
                        end
`endif
                    end
                end
                S_SCAN: begin
                    if (cnt == LAST_IDX) begin
                        cnt   <= '0;
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Status outputs decode directly from the state register.
    assign inv_busy = (state != S_IDLE);
    assign inv_done = (state == S_DONE);
    assign inv_ine  = inv_done & ine_q;
    assign scan_idx = cnt;

    // Clear port: gated by reset so an aborted scan issues no clear in the reset cycle.
    assign clr_we  = (state == S_SCAN) & ~reset & scan_e & pred;
    assign clr_idx = cnt;

`ifdef TLB_INV_FASTALL_EN
    assign clr_all = inv_done & fast_q & ~reset;
`else
    assign clr_all = 1'b0;
`endif

endmodule
